// File: rtl/decoder_arbiter_pkg.sv
// rtl/decoder_arbiter_pkg.sv - shared widths, state encoding and round-robin pick helper
// No ports: imported by the interface, the decoder and the arbiter top.
package decoder_arbiter_pkg;

  localparam int N_REQ  = 16;
  localparam int SEL_W  = 4;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set request at or above ptr, scanning upward and wrapping mod N_REQ.
  // The 4-bit index add wraps naturally, so no explicit modulo is needed.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] idx;
    res.found = 1'b0;
    res.idx   = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_arbiter_if.sv
// rtl/decoder_arbiter_if.sv - request/grant bus between requesters and the arbiter
// req/done      : driven by the requester side (master)
// sel/enable/grant/busy/timeout : driven by the arbiter (slave)
interface decoder_arbiter_if;
  import decoder_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic             enable;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             timeout;

  modport master (
    output req, done,
    input  sel, enable, grant, busy, timeout
  );

  modport slave (
    input  req, done,
    output sel, enable, grant, busy, timeout
  );

endinterface

// File: rtl/decoder_arbiter_dec.sv
// rtl/decoder_arbiter_dec.sv - 4-to-16 one-hot decoder with enable
// sel_i : index to decode
// en_i  : output forced to all-zero when low
// dec_o : one-hot decode of sel_i
module decoder_arbiter_dec
  import decoder_arbiter_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] dec_o
);

  assign dec_o = en_i ? (N_REQ'(1) << sel_i) : '0;

endmodule

// File: rtl/decoder_arbiter.sv
// rtl/decoder_arbiter.sv - round-robin arbiter with hold limit and one-hot grant decode
// clk : rising-edge clock
// rst : asynchronous active-high reset
// bus : decoder_arbiter_if.slave (req/done in; sel/enable/grant/busy/timeout out)
module decoder_arbiter
  import decoder_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  decoder_arbiter_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  ptr_q;
  logic [SEL_W-1:0]  ptr_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              enable_q;
  logic              timeout_q;

  pick_t             pick;
  logic              owner_req;
  logic              at_limit;

  assign pick      = rr_pick(bus.req, ptr_q);
  assign owner_req = bus.req[sel_q];
  assign at_limit  = (hold_q == HOLD_LIM);
  assign hold_d    = hold_q + 1'b1;
  // Priority moves just past the releasing owner; 15 wraps to 0.
  assign ptr_d     = sel_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (pick.found) begin
            state_q  <= GRANT;
            sel_q    <= pick.idx;
            hold_q   <= HOLD_W'(1);
            enable_q <= 1'b1;
          end
        end
        GRANT: begin
          if (bus.done || !owner_req || at_limit) begin
            // Always return through IDLE so grants are separated by a gap.
            state_q   <= IDLE;
            enable_q  <= 1'b0;
            ptr_q     <= ptr_d;
            // Only a forced revoke is a timeout; a voluntary release on the
            // last allowed cycle is not.
            timeout_q <= at_limit && !bus.done && owner_req;
          end else begin
            hold_q    <= hold_d;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.enable  = enable_q;
  assign bus.busy    = enable_q;
  assign bus.timeout = timeout_q;

  // Grant is decoded from registered sel/enable, so reset clears it at once.
  decoder_arbiter_dec u_dec (
    .sel_i (sel_q),
    .en_i  (enable_q),
    .dec_o (bus.grant)
  );

endmodule

// File: doc/decoder_arbiter.md
DECODER_ARBITER -- requirements
Module: decoder_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive cycles one requester may hold the grant (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  16  request vector; bit i high = requester i wants the shared resource.
REQ-005 done  input  1  current owner releases the resource; sampled only in GRANT.
REQ-006 sel  output  4  registered index of the current owner.
REQ-007 enable  output  1  registered; high exactly while in GRANT.
REQ-008 grant  output  16  one-hot decode of sel gated by enable; all-zero when enable low.
REQ-009 busy  output  1  equal to enable.
REQ-010 timeout  output  1  one-cycle registered pulse when a grant is revoked by the HOLD_MAX limit.

Function
REQ-011 FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 IDLE: if req is nonzero, SHALL pick the first set bit at or after ptr, scanning upward mod 16; next state GRANT; sel is loaded with the winner.
REQ-013 IDLE with req all-zero SHALL stay in IDLE; sel, ptr and hold counter unchanged.
REQ-014 Latency: req sampled at edge n SHALL give enable=1 and the grant bit set after edge n, i.e. visible in cycle n+1.
REQ-015 GRANT: hold counter SHALL start at 1 on entry and increment by 1 per cycle spent in GRANT.
REQ-016 GRANT SHALL go to IDLE at the next edge when any of these holds: done=1, req[sel]=0, or hold counter = HOLD_MAX.
REQ-017 If HOLD_MAX is reached with done=0 and req[sel]=1, timeout SHALL pulse high for the cycle following that edge; if done is also high, timeout SHALL stay low.
REQ-018 On every GRANT->IDLE transition, ptr SHALL become sel+1 mod 16 (15 wraps to 0).
REQ-019 At least one IDLE cycle with enable=0 SHALL separate consecutive grants, including when done and a new req coincide.
REQ-020 Requests from other bits that arrive or drop during GRANT SHALL NOT affect sel or enable.
REQ-021 grant SHALL never have more than one bit set; it SHALL equal 1<<sel when enable=1 and 0 otherwise.
REQ-022 Hold counter width SHALL be 8 bits; it SHALL not wrap within a legal HOLD_MAX.

Reset
REQ-023 rst high SHALL force IDLE, sel=0, ptr=0, hold counter=0, enable=0, busy=0, timeout=0, grant=0 immediately, without waiting for clk.
REQ-024 Reset asserted during GRANT SHALL drop grant in the same cycle; after rst deasserts, the first arbitration SHALL start from ptr=0.

Structure
REQ-025 Shared package SHALL hold N_REQ=16, SEL_W=4, HOLD_W=8 and the state encoding (IDLE=0, GRANT=1).
REQ-026 grant SHALL come from one instance of the team's existing 4-to-16 decoder module, driven by sel and enable; no duplicate decode logic.
REQ-027 The round-robin priority pick SHALL be combinational; all outputs except grant SHALL be registered.

Verification
REQ-028 Reset, then req=16'h0001 held, done pulsed in 3rd grant cycle -> sel=0, grant=16'h0001 for 3 cycles, one IDLE cycle, regrant to 0.
REQ-029 req=16'h8001 held, done=1 each grant's 1st cycle -> grant alternates 16'h0001, 16'h8000, 16'h0001 with one-cycle gaps; ptr wraps 15->0.
REQ-030 HOLD_MAX=8, req=16'h0010 held, done=0 -> grant 16'h0010 for exactly 8 cycles, then timeout=1 for one cycle, enable=0.
REQ-031 Owner 5 active, req[5] drops mid-grant while req[9] rises -> enable=0 next cycle, then sel=9 the cycle after.
REQ-032 rst asserted between edges during GRANT with sel=7 -> grant=0 and busy=0 before the next edge; after release, req=16'hFFFF grants bit 0 first.
REQ-033 Random req/done for 10000 cycles -> grant one-hot or zero, every grant preceded by an IDLE cycle, no requester held more than HOLD_MAX cycles.
